// File: rtl/cal_gyro.sv
// Three-axis gyro rate integrator: scales raw MPU rate words and accumulates
// rate*dt into saturating signed 24-bit angle registers.
module cal_gyro #(
    parameter int unsigned dt         = 1,
    parameter int          RATE_SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cal_gyro_en,
    input  logic [7:0]  mpu_data_packed_8,
    input  logic [7:0]  mpu_data_packed_9,
    input  logic [7:0]  mpu_data_packed_10,
    input  logic [7:0]  mpu_data_packed_11,
    input  logic [7:0]  mpu_data_packed_12,
    input  logic [7:0]  mpu_data_packed_13,
    output logic [23:0] cur_pitch_gyro,
    output logic [23:0] cur_roll_gyro,
    output logic [23:0] cur_yaw_gyro
);

    localparam int ANGLE_W = 24;
    localparam int RAW_W   = 16;
    localparam int DT_W    = 17;
    // Wide enough for any shift setting: a 16-bit rate times a 17-bit signed dt,
    // plus headroom for adding the 24-bit angle without overflow.
    localparam int INC_W   = RAW_W + DT_W;
    localparam int SUM_W   = INC_W + 2;

    localparam logic signed [DT_W-1:0]  DT_S      = $signed({1'b0, 16'(dt)});
    localparam logic signed [SUM_W-1:0] ANGLE_MAX = SUM_W'(8388607);
    localparam logic signed [SUM_W-1:0] ANGLE_MIN = -SUM_W'(8388608);

    function automatic logic signed [ANGLE_W-1:0] sat24(input logic signed [SUM_W-1:0] s);
        if (s > ANGLE_MAX)
            return 24'sh7FFFFF;
        else if (s < ANGLE_MIN)
            return 24'sh800000;
        else
            return s[ANGLE_W-1:0];
    endfunction

    function automatic logic [ANGLE_W-1:0] next_angle(
        input logic [ANGLE_W-1:0] angle,
        input logic [RAW_W-1:0]   raw
    );
        logic signed [RAW_W-1:0] rate;
        logic signed [INC_W-1:0] inc;
        logic signed [SUM_W-1:0] sum;
        rate = $signed(raw) >>> RATE_SHIFT;
        inc  = INC_W'(rate) * INC_W'(DT_S);
        sum  = SUM_W'($signed(angle)) + SUM_W'(inc);
        return sat24(sum);
    endfunction

    // Single registered stage: sample at the edge, angle visible right after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_pitch_gyro <= '0;
            cur_roll_gyro  <= '0;
            cur_yaw_gyro   <= '0;
        end else if (cal_gyro_en) begin
            cur_pitch_gyro <= next_angle(cur_pitch_gyro, {mpu_data_packed_9,  mpu_data_packed_8});
            cur_roll_gyro  <= next_angle(cur_roll_gyro,  {mpu_data_packed_11, mpu_data_packed_10});
            cur_yaw_gyro   <= next_angle(cur_yaw_gyro,   {mpu_data_packed_13, mpu_data_packed_12});
        end
    end

endmodule

// File: tb/tb_cal_gyro.sv
// Bench for cal_gyro: three instances (dt = 1, 65535, 3) share stimulus and are
// checked each cycle against an integer angle model plus literal expectations.
module tb_cal_gyro;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic [7:0] p8 = '0, p9 = '0, p10 = '0, p11 = '0, p12 = '0, p13 = '0;
    logic [23:0] pa1, ra1, ya1, pa2, ra2, ya2, pa3, ra3, ya3;

    int errors = 0;
    int checks = 0;

    int dts [3] = '{1, 65535, 3};
    int model [3][3] = '{default: 0};

    always #5 clk = ~clk;

    cal_gyro #(.dt(1), .RATE_SHIFT(8)) u_dt1 (
        .clk(clk), .rst_n(rst_n), .cal_gyro_en(en),
        .mpu_data_packed_8(p8), .mpu_data_packed_9(p9),
        .mpu_data_packed_10(p10), .mpu_data_packed_11(p11),
        .mpu_data_packed_12(p12), .mpu_data_packed_13(p13),
        .cur_pitch_gyro(pa1), .cur_roll_gyro(ra1), .cur_yaw_gyro(ya1));

    cal_gyro #(.dt(65535), .RATE_SHIFT(8)) u_dt65535 (
        .clk(clk), .rst_n(rst_n), .cal_gyro_en(en),
        .mpu_data_packed_8(p8), .mpu_data_packed_9(p9),
        .mpu_data_packed_10(p10), .mpu_data_packed_11(p11),
        .mpu_data_packed_12(p12), .mpu_data_packed_13(p13),
        .cur_pitch_gyro(pa2), .cur_roll_gyro(ra2), .cur_yaw_gyro(ya2));

    cal_gyro #(.dt(3), .RATE_SHIFT(8)) u_dt3 (
        .clk(clk), .rst_n(rst_n), .cal_gyro_en(en),
        .mpu_data_packed_8(p8), .mpu_data_packed_9(p9),
        .mpu_data_packed_10(p10), .mpu_data_packed_11(p11),
        .mpu_data_packed_12(p12), .mpu_data_packed_13(p13),
        .cur_pitch_gyro(pa3), .cur_roll_gyro(ra3), .cur_yaw_gyro(ya3));

    function automatic int dut_val(int i, int a);
        logic [23:0] v;
        case (i * 3 + a)
            0: v = pa1;  1: v = ra1;  2: v = ya1;
            3: v = pa2;  4: v = ra2;  5: v = ya2;
            6: v = pa3;  7: v = ra3;  default: v = ya3;
        endcase
        return int'($signed(v));
    endfunction

    // Rate = floor(raw / 256), written as plain integer division.
    function automatic int rate_of(logic [7:0] msb, logic [7:0] lsb);
        int raw;
        raw = int'($signed({msb, lsb}));
        if (raw >= 0)
            return raw / 256;
        else
            return -((-raw + 255) / 256);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int a = 0; a < 3; a++)
                    model[i][a] = 0;
        end else if (en) begin
            int r [3];
            r[0] = rate_of(p9, p8);
            r[1] = rate_of(p11, p10);
            r[2] = rate_of(p13, p12);
            for (int i = 0; i < 3; i++)
                for (int a = 0; a < 3; a++) begin
                    longint s;
                    s = longint'(model[i][a]) + longint'(r[a]) * longint'(dts[i]);
                    if (s > 8388607) s = 8388607;
                    if (s < -8388608) s = -8388608;
                    model[i][a] = int'(s);
                end
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 3; a++)
                check($sformatf("model[%0d][%0d] t=%0t", i, a, $time), dut_val(i, a), model[i][a]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(logic [15:0] p, logic [15:0] r, logic [15:0] y);
        {p9, p8}   = p;
        {p11, p10} = r;
        {p13, p12} = y;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) tick();
        check("reset pitch", dut_val(0, 0), 0);
        check("reset roll",  dut_val(0, 1), 0);
        check("reset yaw",   dut_val(0, 2), 0);
        rst_n = 1'b1;
        tick();

        set_in(16'h0100, 16'hFFFF, 16'h0200);
        en = 1'b1;
        repeat (10) tick();
        check("ten pitch", dut_val(0, 0), 10);
        check("ten roll",  dut_val(0, 1), -10);
        check("ten yaw",   dut_val(0, 2), 20);

        set_in(16'h0200, 16'hFFFE, 16'h0300);
        repeat (5) tick();
        check("fifteen pitch", dut_val(0, 0), 20);
        check("fifteen roll",  dut_val(0, 1), -15);
        check("fifteen yaw",   dut_val(0, 2), 35);

        en = 1'b0;
        set_in(16'h1234, 16'h5678, 16'h9ABC);
        repeat (5) tick();
        check("hold pitch", dut_val(0, 0), 20);
        check("hold roll",  dut_val(0, 1), -15);
        check("hold yaw",   dut_val(0, 2), 35);

        // Reset asserted between edges must clear at once.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async pitch", dut_val(0, 0), 0);
        check("async roll",  dut_val(0, 1), 0);
        check("async yaw",   dut_val(0, 2), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post-reset pitch", dut_val(0, 0), 0);
        check("post-reset yaw",   dut_val(0, 2), 0);

        set_in(16'h0000, 16'hFE00, 16'h0000);
        en = 1'b1;
        repeat (3) tick();
        check("roll FE00", dut_val(0, 1), -6);
        en = 1'b0;

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        set_in(16'h7FFF, 16'h8000, 16'h0000);
        en = 1'b1;
        repeat (1100) tick();
        check("sat pos pitch", dut_val(1, 0), 8388607);
        check("sat neg roll",  dut_val(1, 1), -8388608);
        check("dt1 pitch",     dut_val(0, 0), 139700);
        check("dt1 roll",      dut_val(0, 1), -140800);
        set_in(16'h8000, 16'h7FFF, 16'h0000);
        tick();
        check("unsat pitch", dut_val(1, 0), 127);
        check("unsat roll",  dut_val(1, 1), -65663);
        en = 1'b0;

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        set_in(16'h0000, 16'h0000, 16'h0500);
        en = 1'b1;
        repeat (4) tick();
        check("dt3 yaw",   dut_val(2, 2), 60);
        check("dt3 pitch", dut_val(2, 0), 0);
        en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
